// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 keyboard receiver and game key decoder.
// Synchronizes and glitch-filters the PS/2 lines, frames 11-bit PS/2 words
// (start, 8 data LSB first, odd parity, stop), and maps E0/F0 prefixed scan
// codes to a 2-bit key pulse (01 left, 10 right, 11 space).
// Optional macro KEY_REPEAT_EN: when defined, repeated make codes each pulse.
module ps2_key_decoder #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 13000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [1:0] key,
    output logic       frame_error
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          sample;

    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          byte_stb_q, byte_stb_d;
    logic          err_stb_q, err_stb_d;
    logic          timeout_hit;

    logic          ext_q, ext_d, brk_q, brk_d;
    logic [2:0]    held_q, held_d;
    logic [1:0]    key_q, key_d;
    logic          ferr_q, ferr_d;
    logic [1:0]    code;
    logic [2:0]    sel;

    // Glitch filter: the filtered level follows only after FILTER_LEN equal samples
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (clk_s2_q != filt_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = clk_s2_q;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end
    end

    assign sample = filt_q & ~filt_d;

    // Frame FSM next state: bit assembly, parity/stop checks and stall timeout
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        to_cnt_d    = to_cnt_q;
        byte_stb_d  = 1'b0;
        err_stb_d   = 1'b0;
        timeout_hit = 1'b0;
        if (state_q == S_IDLE) begin
            to_cnt_d = '0;
            if (sample && !dat_s2_q) begin
                state_d   = S_DATA;
                bit_cnt_d = '0;
            end
        end else if (sample) begin
            to_cnt_d = '0;
            case (state_q)
                S_DATA: begin
                    shift_d   = {dat_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                end
                S_PARITY: begin
                    par_d   = dat_s2_q;
                    state_d = S_STOP;
                end
                default: begin
                    if (dat_s2_q && (^{shift_q, par_q})) byte_stb_d = 1'b1;
                    else                                 err_stb_d  = 1'b1;
                    state_d = S_IDLE;
                end
            endcase
        end else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            timeout_hit = 1'b1;
            state_d     = S_IDLE;
        end else begin
            to_cnt_d = to_cnt_q + TW'(1);
        end
    end

    // Scan-code decoder: prefix flags, held flags and output pulses
    always_comb begin
        ext_d  = ext_q;
        brk_d  = brk_q;
        held_d = held_q;
        key_d  = '0;
        ferr_d = err_stb_q | timeout_hit;
        code   = 2'b00;
        if (ext_q && shift_q == 8'h6B)       code = 2'b01;
        else if (ext_q && shift_q == 8'h74)  code = 2'b10;
        else if (!ext_q && shift_q == 8'h29) code = 2'b11;
        case (code)
            2'b01:   sel = 3'b001;
            2'b10:   sel = 3'b010;
            2'b11:   sel = 3'b100;
            default: sel = 3'b000;
        endcase
        if (ferr_d) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_stb_q) begin
            if (shift_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                if (brk_q) begin
                    held_d = held_q & ~sel;
                end else begin
`ifdef KEY_REPEAT_EN
                    key_d = code;
`else
                    if ((held_q & sel) == 3'b000) key_d = code;
`endif
                    held_d = held_q | sel;
                end
            end
        end
    end

    // State registers; synchronizers and filter idle high like the PS/2 bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
            filt_q     <= 1'b1;
            fcnt_q     <= '0;
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            to_cnt_q   <= '0;
            byte_stb_q <= 1'b0;
            err_stb_q  <= 1'b0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            held_q     <= '0;
            key_q      <= '0;
            ferr_q     <= 1'b0;
        end else begin
            clk_s1_q   <= ps2_clk;
            clk_s2_q   <= clk_s1_q;
            dat_s1_q   <= ps2_data;
            dat_s2_q   <= dat_s1_q;
            filt_q     <= filt_d;
            fcnt_q     <= fcnt_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            to_cnt_q   <= to_cnt_d;
            byte_stb_q <= byte_stb_d;
            err_stb_q  <= err_stb_d;
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            held_q     <= held_d;
            key_q      <= key_d;
            ferr_q     <= ferr_d;
        end
    end

    assign key         = key_q;
    assign frame_error = ferr_q;

endmodule
